imsic_msi_gate_q: RTL

//  Per-hart IMSIC MSI gate with buffered delivery. Receives MSIs over a 4-phase req/ack link, synchronises req,

---
 rtl/imsic_msi_gate_q.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/imsic_msi_gate_q.sv
// imsic_msi_gate_q: per-hart IMSIC MSI gate with a buffered delivery queue.
// MSIs arrive over a 4-phase req/ack link from a foreign clock domain. Each MSI
// is queued, then drained into the per-file eip pending bits. Draining
// arbitrates against CSR claims and software eip writes. The block also maps
// the CSR privilege level to an interrupt file.
//
// Handshake FSM
//   state    | meaning
//   ST_IDLE  | ack low; push the next MSI once the synchronised req is high and the queue has room
//   ST_ACKED | ack high; wait for the synchronised req to fall
module imsic_msi_gate_q #(
  parameter int NR_INTP_FILES  = 7,
  parameter int XLEN           = 64,
  parameter int NR_HARTS       = 4,
  parameter int NR_HARTS_WIDTH = 2,
  parameter int NR_SRC         = 256,
  parameter int FIFO_DEPTH     = 4,
  parameter int EID_VLD_DLY    = 0,
  localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
  localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
  localparam int NR_REG          = (NR_SRC + XLEN - 1) / XLEN,
  localparam int NR_EIP          = NR_INTP_FILES * NR_REG,
  localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
  localparam int CNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [NR_HARTS_WIDTH-1:0]              hart_id,
  input  logic [MSI_INFO_WIDTH-1:0]              i_msi_info,
  input  logic                                   i_msi_req,
  output logic                                   o_msi_ack,
  input  logic                                   i_csr_addr_vld,
  input  logic [1:0]                             i_csr_priv_lvl,
  input  logic                                   i_csr_v,
  input  logic [5:0]                             i_csr_vgein,
  input  logic [2:0]                             i_csr_claim,
  input  logic [NR_INTP_FILES-1:0][31:0]         xtopei,
  input  logic [NR_EIP-1:0][XLEN-1:0]            eip_sw,
  input  logic [NR_EIP-1:0]                      eip_sw_wr,
  output logic [INTP_FILE_WIDTH-1:0]             intp_file_sel,
  output logic                                   priv_is_illegal,
  output logic                                   vgein_legal,
  output logic [NR_EIP-1:0][XLEN-1:0]            eip_final,
  output logic [CNT_WIDTH-1:0]                   o_fifo_cnt,
  output logic [7:0]                             o_drop_cnt
);

  localparam int SYNC_N = EID_VLD_DLY + 3;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BIT_W  = $clog2(XLEN);

  typedef enum logic {ST_IDLE, ST_ACKED} hs_state_t;

  hs_state_t                  hs_state, hs_state_nxt;
  logic [SYNC_N-1:0]          req_sync;
  logic                       req_s;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [MSI_INFO_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [CNT_WIDTH-1:0]       fifo_cnt;

  logic [MSI_INFO_WIDTH-1:0]  head;
  logic [NR_HARTS_WIDTH-1:0]  pop_hart;
  logic [INTP_FILE_WIDTH-1:0] pop_file;
  logic [NR_SRC_WIDTH-1:0]    pop_id;
  logic                       pop_valid;
  logic                       pop_set;
  logic                       pop_drop;

  int                         set_reg;
  logic [BIT_W-1:0]           set_bit;
  logic [NR_EIP-1:0][XLEN-1:0] set_vec;

  int                         claim_file;
  logic [31:0]                claim_top;
  int                         claim_id;
  int                         claim_reg;
  logic [BIT_W-1:0]           claim_bit;
  logic                       claim_act;
  logic [NR_EIP-1:0][XLEN-1:0] clr_vec;
  logic [NR_EIP-1:0][XLEN-1:0] eip_nxt;

  // Bring the foreign-domain request into clk through an N-deep flop chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) req_sync <= '0;
    else       req_sync <= {req_sync[SYNC_N-2:0], i_msi_req};
  end

  assign req_s = req_sync[SYNC_N-1];

  // Handshake state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hs_state <= ST_IDLE;
    else       hs_state <= hs_state_nxt;
  end

  // Handshake next state: a full queue holds us in IDLE, so ack is withheld until a slot frees
  always_comb begin
    hs_state_nxt = hs_state;
    case (hs_state)
      ST_IDLE:  if (req_s && !fifo_full) hs_state_nxt = ST_ACKED;
      ST_ACKED: if (!req_s)              hs_state_nxt = ST_IDLE;
      default:                           hs_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake outputs: ack is a direct decode of the state flop
  always_comb begin
    o_msi_ack = (hs_state == ST_ACKED);
    push      = (hs_state == ST_IDLE) && req_s && !fifo_full;
  end

  assign fifo_full  = (fifo_cnt == CNT_WIDTH'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign pop        = !fifo_empty && (i_csr_claim == 3'b000);
  assign o_fifo_cnt = fifo_cnt;

  // Queue storage; contents need no reset because the count gates every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= i_msi_info;
  end

  // Queue pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_WIDTH'(1);
      else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_WIDTH'(1);
    end
  end

  // Decode the head entry and decide whether it targets a legal identity on this hart
  always_comb begin
    head      = fifo_mem[rd_ptr];
    pop_hart  = head[MSI_INFO_WIDTH-1 -: NR_HARTS_WIDTH];
    pop_file  = head[NR_SRC_WIDTH +: INTP_FILE_WIDTH];
    pop_id    = head[NR_SRC_WIDTH-1:0];
    pop_valid = ((NR_HARTS == 1) || (pop_hart == hart_id)) &&
                (int'(pop_file) < NR_INTP_FILES) &&
                (pop_id != '0) && (int'(pop_id) < NR_SRC);
    pop_set   = pop && pop_valid;
    pop_drop  = pop && !pop_valid;
  end

  // One-hot set mask for the popped MSI
  always_comb begin
    set_reg = int'(pop_file) * NR_REG + int'(pop_id) / XLEN;
    set_bit = BIT_W'(int'(pop_id) % XLEN);
    for (int r = 0; r < NR_EIP; r++) begin
      set_vec[r] = '0;
      if (pop_set && (r == set_reg)) set_vec[r][set_bit] = 1'b1;
    end
  end

  // One-hot clear mask for a CSR claim; M wins over S, which wins over the guest file
  always_comb begin
    if (i_csr_claim[0])      claim_file = 0;
    else if (i_csr_claim[1]) claim_file = 1;
    else                     claim_file = 1 + int'(i_csr_vgein);
    claim_top = '0;
    for (int f = 0; f < NR_INTP_FILES; f++) begin
      if (f == claim_file) claim_top = xtopei[f];
    end
    claim_id  = int'(claim_top & 32'((1 << NR_SRC_WIDTH) - 1));
    claim_reg = claim_file * NR_REG + claim_id / XLEN;
    claim_bit = BIT_W'(claim_id % XLEN);
    claim_act = (i_csr_claim != 3'b000) && (claim_id != 0) && (claim_file < NR_INTP_FILES);
    for (int r = 0; r < NR_EIP; r++) begin
      clr_vec[r] = '0;
      if (claim_act && (r == claim_reg)) clr_vec[r][claim_bit] = 1'b1;
    end
  end

  // Merge per register: SW data replaces the old value, a popped MSI is never lost, a claim clears last
  always_comb begin
    for (int r = 0; r < NR_EIP; r++) begin
      eip_nxt[r] = ((eip_sw_wr[r] ? eip_sw[r] : eip_final[r]) | set_vec[r]) & ~clr_vec[r];
    end
  end

  // Pending-bit register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) eip_final <= '0;
    else       eip_final <= eip_nxt;
  end

  // Count MSIs discarded for a bad hart, file or identity; saturates at 255
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                             o_drop_cnt <= '0;
    else if (pop_drop && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 8'd1;
  end

  assign vgein_legal = (i_csr_vgein != '0) && (int'(i_csr_vgein) <= NR_INTP_FILES - 2);

  // Map the CSR privilege and virtualisation mode to an interrupt file
  always_comb begin
    intp_file_sel   = '0;
    priv_is_illegal = 1'b0;
    if (i_csr_addr_vld) begin
      if (!i_csr_v) begin
        if (i_csr_priv_lvl == 2'b11)      intp_file_sel = INTP_FILE_WIDTH'(0);
        else if (i_csr_priv_lvl == 2'b01) intp_file_sel = INTP_FILE_WIDTH'(1);
        else                              priv_is_illegal = 1'b1;
      end else begin
        if ((i_csr_priv_lvl == 2'b01) && vgein_legal)
          intp_file_sel = INTP_FILE_WIDTH'(1 + int'(i_csr_vgein));
        else
          priv_is_illegal = 1'b1;
      end
    end
  end

endmodule
